// File: rtl/irq_core_bridge_if.sv
// Bridge-side bundle: pending/enable from the service unit, request/ack to the core.
// master = the bridge, slave = the service unit plus the core.
interface irq_core_bridge_if #(parameter int NUM_IRQ = 32);
  logic [NUM_IRQ-1:0] irq_pending_i;
  logic               irq_enable_i;
  logic               core_irq_o;
  logic [4:0]         core_irq_id_o;
  logic               core_irq_ack_i;
  logic               irq_ack_o;
  logic [4:0]         irq_id_o;
  logic               spurious_ack_o;

  modport master (
    input  irq_pending_i, irq_enable_i, core_irq_ack_i,
    output core_irq_o, core_irq_id_o, irq_ack_o, irq_id_o, spurious_ack_o
  );
  modport slave (
    output irq_pending_i, irq_enable_i, core_irq_ack_i,
    input  core_irq_o, core_irq_id_o, irq_ack_o, irq_id_o, spurious_ack_o
  );
endinterface

// File: rtl/irq_core_bridge.sv
// Interrupt bridge: arbitrates pending lines, requests the core, returns the ack to the service unit.
// IRQ_BRIDGE_RR_EN selects round-robin arbitration; otherwise lowest index wins.
module irq_core_bridge #(
  parameter int NUM_IRQ = 32
) (
  input  logic HCLK,
  input  logic HRESET,
  irq_core_bridge_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, ACK, HOLD} state_e;

  state_e     state_q, state_d;
  logic [4:0] id_q, id_d;
  logic [4:0] ack_id_q, ack_id_d;
  logic       spur_q, spur_d;
  logic       rdy_q;
  logic [4:0] win_id;
  logic       win_vld;

`ifdef IRQ_BRIDGE_RR_EN
  logic [4:0] ptr_q, ptr_d;
  logic [5:0] idx;

  // Search starts at the pointer and wraps, first hit wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      idx = 6'(ptr_q) + 6'(i);
      if (idx >= 6'(NUM_IRQ)) idx = idx - 6'(NUM_IRQ);
      if (!win_vld && bus.irq_pending_i[idx[4:0]]) begin
        win_vld = 1'b1;
        win_id  = idx[4:0];
      end
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = NUM_IRQ-1; i >= 0; i--) begin
      if (bus.irq_pending_i[i]) begin
        win_vld = 1'b1;
        win_id  = 5'(i);
      end
    end
  end
`endif

  // rdy_q holds off arbitration for the first edge after reset release.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= IDLE;
      id_q     <= '0;
      ack_id_q <= '0;
      spur_q   <= 1'b0;
      rdy_q    <= 1'b0;
`ifdef IRQ_BRIDGE_RR_EN
      ptr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      ack_id_q <= ack_id_d;
      spur_q   <= spur_d;
      rdy_q    <= 1'b1;
`ifdef IRQ_BRIDGE_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    ack_id_d = ack_id_q;
    spur_d   = bus.core_irq_ack_i && (state_q != REQ);
`ifdef IRQ_BRIDGE_RR_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      IDLE: if (rdy_q && bus.irq_enable_i && win_vld) begin
        id_d    = win_id;
        state_d = REQ;
      end
      // Ack beats a same-cycle withdrawal.
      REQ: if (bus.core_irq_ack_i) begin
        state_d  = ACK;
        ack_id_d = id_q;
      end else if (!bus.irq_enable_i || !bus.irq_pending_i[id_q]) begin
        state_d = IDLE;
      end
      ACK: begin
        state_d = HOLD;
`ifdef IRQ_BRIDGE_RR_EN
        ptr_d = (id_q == 5'(NUM_IRQ-1)) ? 5'd0 : id_q + 5'd1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.core_irq_o     = (state_q == REQ);
    bus.core_irq_id_o  = id_q;
    bus.irq_ack_o      = (state_q == ACK);
    bus.irq_id_o       = ack_id_q;
    bus.spurious_ack_o = spur_q;
  end
endmodule

// File: tb/tb_irq_core_bridge.sv
// Directed bench for irq_core_bridge; ack ids are scoreboarded and checked when irq_ack_o fires.
module tb_irq_core_bridge;
  logic HCLK = 1'b0;
  logic HRESET;
  int   total = 0;
  int   passed = 0;
  logic [4:0] exp_q[$];

  irq_core_bridge_if #(.NUM_IRQ(32)) bif();
  irq_core_bridge #(.NUM_IRQ(32)) dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bif.master));

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge HCLK); #1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (bif.core_irq_o !== 1'b1 && n < 10) begin tick(); n++; end
    chk(tag, 32'(bif.core_irq_o), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_core_irq"}, 32'(bif.core_irq_o), 32'd0);
    chk({tag, "_core_id"},  32'(bif.core_irq_id_o), 32'd0);
    chk({tag, "_ack"},      32'(bif.irq_ack_o), 32'd0);
    chk({tag, "_ack_id"},   32'(bif.irq_id_o), 32'd0);
    chk({tag, "_spur"},     32'(bif.spurious_ack_o), 32'd0);
  endtask

  // Scoreboard consumer: every ack pulse must match the oldest expected id.
  always @(negedge HCLK) begin
    if (bif.irq_ack_o === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
      else chk("ack_id", 32'(bif.irq_id_o), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    logic [4:0] rr_exp [3];
`ifdef IRQ_BRIDGE_RR_EN
    rr_exp = '{5'd0, 5'd1, 5'd0};
`else
    rr_exp = '{5'd0, 5'd0, 5'd0};
`endif
    HRESET = 1'b1;
    bif.irq_pending_i  = '0;
    bif.irq_enable_i   = 1'b0;
    bif.core_irq_ack_i = 1'b0;
    tick(); tick();
    chk_all_zero("reset");

    // Basic request/ack with pending 0x14 -> id 2
    bif.irq_pending_i = 32'h0000_0014;
    bif.irq_enable_i  = 1'b1;
    HRESET = 1'b0;
    tick();
    chk("release_gap", 32'(bif.core_irq_o), 32'd0);
    tick();
    chk("req_0x14", 32'(bif.core_irq_o), 32'd1);
    chk("req_id_0x14", 32'(bif.core_irq_id_o), 32'd2);
    bif.core_irq_ack_i = 1'b1;
    exp_q.push_back(5'd2);
    tick();
    chk("ack_state", 32'(bif.irq_ack_o), 32'd1);
    chk("ack_req_drop", 32'(bif.core_irq_o), 32'd0);
    bif.core_irq_ack_i = 1'b0;
    bif.irq_pending_i  = '0;
    tick();
    chk("hold_ack", 32'(bif.irq_ack_o), 32'd0);
    chk("hold_req", 32'(bif.core_irq_o), 32'd0);
    chk("hold_id_kept", 32'(bif.irq_id_o), 32'd2);
    chk("hold_spur", 32'(bif.spurious_ack_o), 32'd0);
    tick();
    chk("idle_req", 32'(bif.core_irq_o), 32'd0);

    // Software clear before ack withdraws the request
    bif.irq_pending_i = 32'h0000_0020;
    tick();
    chk("req5", 32'(bif.core_irq_o), 32'd1);
    chk("req5_id", 32'(bif.core_irq_id_o), 32'd5);
    bif.irq_pending_i = '0;
    tick();
    chk("withdraw_req", 32'(bif.core_irq_o), 32'd0);
    chk("withdraw_noack", 32'(bif.irq_ack_o), 32'd0);
    tick();
    chk("withdraw_idle", 32'(bif.core_irq_o), 32'd0);

    // Ack and clear in the same cycle: ack wins
    bif.irq_pending_i = 32'h0000_0020;
    tick();
    chk("req5b", 32'(bif.core_irq_o), 32'd1);
    bif.core_irq_ack_i = 1'b1;
    bif.irq_pending_i  = '0;
    exp_q.push_back(5'd5);
    tick();
    chk("ack_wins", 32'(bif.irq_ack_o), 32'd1);
    bif.core_irq_ack_i = 1'b0;
    tick(); tick();

    // id stays stable when a higher-priority line appears; disable withdraws
    bif.irq_pending_i = 32'h0000_0020;
    tick();
    bif.irq_pending_i = 32'h0000_0022;
    tick();
    chk("stable_req", 32'(bif.core_irq_o), 32'd1);
    chk("stable_id", 32'(bif.core_irq_id_o), 32'd5);
    bif.irq_enable_i = 1'b0;
    tick();
    chk("disable_withdraw", 32'(bif.core_irq_o), 32'd0);
    tick();
    chk("disable_blocks", 32'(bif.core_irq_o), 32'd0);
    bif.irq_pending_i = '0;
    bif.irq_enable_i  = 1'b1;
    tick();

    // Ack while idle is spurious
    bif.core_irq_ack_i = 1'b1;
    tick();
    bif.core_irq_ack_i = 1'b0;
    chk("spur_pulse", 32'(bif.spurious_ack_o), 32'd1);
    chk("spur_noreq", 32'(bif.core_irq_o), 32'd0);
    chk("spur_noack", 32'(bif.irq_ack_o), 32'd0);
    tick();
    chk("spur_end", 32'(bif.spurious_ack_o), 32'd0);

    // Arbitration rounds with pending 0x3 held, from a fresh reset
    HRESET = 1'b1;
    tick();
    bif.irq_pending_i = 32'h0000_0003;
    HRESET = 1'b0;
    for (int r = 0; r < 3; r++) begin
      wait_req($sformatf("rr_req%0d", r));
      chk($sformatf("rr_id%0d", r), 32'(bif.core_irq_id_o), 32'(rr_exp[r]));
      bif.core_irq_ack_i = 1'b1;
      exp_q.push_back(rr_exp[r]);
      tick();
      bif.core_irq_ack_i = 1'b0;
      tick(); tick();
    end
    bif.irq_pending_i = '0;
    tick(); tick();

    // Reset during ACK drops everything at once, no late ack
    bif.irq_pending_i = 32'h0000_0010;
    wait_req("pre_rst_req");
    bif.core_irq_ack_i = 1'b1;
    tick();
    bif.core_irq_ack_i = 1'b0;
    chk("pre_rst_ack", 32'(bif.irq_ack_o), 32'd1);
    HRESET = 1'b1;
    #1;
    chk_all_zero("rst_in_ack");
    tick();
    chk_all_zero("rst_held");
    HRESET = 1'b0;
    tick();
    chk_all_zero("rst_rel1");
    tick();
    chk("rst_rel2_req", 32'(bif.core_irq_o), 32'd1);
    chk("rst_rel2_id", 32'(bif.core_irq_id_o), 32'd4);
    bif.irq_pending_i = '0;
    tick(); tick();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
